// File: rtl/vmem_seq.sv
// vmem_seq: splits one strided vector load/store command into single-element data_mem accesses.
// One access outstanding at a time; a watchdog aborts the command if data_mem never reports done.
module vmem_seq #(
  parameter int VLEN = 8,
  parameter int TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_rw,
  input  logic [5:0]  cmd_addr,
  input  logic [2:0]  cmd_bank,
  input  logic [5:0]  cmd_stride,
  input  logic [3:0]  cmd_len,
  output logic        cmd_done,
  output logic        cmd_err,
  output logic [2:0]  vr_rd_idx,
  input  logic [31:0] vr_rd_data,
  output logic        vr_wr_en,
  output logic [2:0]  vr_wr_idx,
  output logic [31:0] vr_wr_data,
  output logic        mem_start,
  output logic        mem_rw,
  output logic [5:0]  mem_addr,
  output logic [2:0]  mem_bank,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  input  logic        mem_ready,
  input  logic        mem_done
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FIN, ERR} state_t;
  state_t state, next;
  logic [3:0] len;
  logic [5:0] stride;
  logic [TW-1:0] wd;
  logic last, tmo, got;
  assign last = {1'b0, vr_rd_idx} == len - 4'd1;
  assign tmo = wd == TW'(TIMEOUT - 1);
  assign got = state == WAIT && mem_done;
  assign cmd_ready = state == IDLE;
  // store data flows straight from the register file, idx is frozen during ISSUE
  assign mem_din = state == ISSUE ? vr_rd_data : '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  // done has priority over the watchdog in the same cycle
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = cmd_valid ? (cmd_len == 4'd0 ? FIN : ISSUE) : IDLE;
      ISSUE:   next = mem_ready ? WAIT : ISSUE;
      WAIT:    next = mem_done ? (last ? FIN : ISSUE) : (tmo ? ERR : WAIT);
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mem_start  <= 1'b0;
      mem_rw     <= 1'b0;
      mem_addr   <= '0;
      mem_bank   <= '0;
      stride     <= '0;
      len        <= '0;
      wd         <= '0;
      vr_rd_idx  <= '0;
      vr_wr_en   <= 1'b0;
      vr_wr_idx  <= '0;
      vr_wr_data <= '0;
      cmd_done   <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      mem_start <= next == ISSUE;
      cmd_done  <= next == FIN;
      cmd_err   <= next == ERR;
      vr_wr_en  <= got && !mem_rw;
      wd        <= state == WAIT ? wd + 1'b1 : '0;
      if (state == IDLE && cmd_valid) begin
        mem_rw    <= cmd_rw;
        mem_addr  <= cmd_addr;
        mem_bank  <= cmd_bank;
        stride    <= cmd_stride;
        len       <= cmd_len > 4'(VLEN) ? 4'(VLEN) : cmd_len;
        vr_rd_idx <= '0;
      end
      if (got && !mem_rw) begin
        vr_wr_data <= mem_dout;
        vr_wr_idx  <= vr_rd_idx;
      end
      if (got && !last) begin
        vr_rd_idx <= vr_rd_idx + 3'd1;
        mem_addr  <= mem_addr + stride;
      end
    end
endmodule

// File: tb/tb_vmem_seq.sv
// tb_vmem_seq: directed bench for vmem_seq with a behavioural data_mem and expected-access/write queues.
module tb_vmem_seq;
  localparam int VLEN = 8;
  localparam int TIMEOUT = 32;
  logic clk = 0, reset = 1;
  logic cmd_valid = 0, cmd_ready, cmd_rw = 0;
  logic [5:0] cmd_addr = 0, cmd_stride = 0;
  logic [2:0] cmd_bank = 0;
  logic [3:0] cmd_len = 0;
  logic cmd_done, cmd_err;
  logic [2:0] vr_rd_idx, vr_wr_idx;
  logic [31:0] vr_rd_data, vr_wr_data;
  logic vr_wr_en, mem_start, mem_rw;
  logic [5:0] mem_addr;
  logic [2:0] mem_bank;
  logic [31:0] mem_din;
  logic [31:0] mem_dout = 0;
  logic mem_ready = 1, mem_done = 0;

  always #5 clk = ~clk;

  vmem_seq #(.VLEN(VLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_bank(cmd_bank), .cmd_stride(cmd_stride), .cmd_len(cmd_len),
    .cmd_done(cmd_done), .cmd_err(cmd_err), .vr_rd_idx(vr_rd_idx), .vr_rd_data(vr_rd_data),
    .vr_wr_en(vr_wr_en), .vr_wr_idx(vr_wr_idx), .vr_wr_data(vr_wr_data), .mem_start(mem_start),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_bank(mem_bank), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_ready(mem_ready), .mem_done(mem_done)
  );

  typedef struct packed {logic rw; logic [2:0] bank; logic [5:0] addr; logic [31:0] din;} acc_t;
  typedef struct packed {logic [2:0] idx; logic [31:0] data;} wr_t;
  acc_t exp_acc[$];
  wr_t exp_wr[$];
  logic [31:0] vr [8];
  logic [31:0] mem [8][64];
  assign vr_rd_data = vr[vr_rd_idx];

  int n_assert = 0, n_fail = 0;
  int acc_cnt = 0, done_cnt = 0, err_cnt = 0;
  int stall = 0, lat = 1, cnt = 0;
  bit pending = 0, no_done = 0;
  logic [2:0] pb;
  logic [5:0] pa;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // data_mem model plus monitors; everything happens on the falling edge
  always @(negedge clk) begin
    acc_t a;
    wr_t w;
    if (cmd_done) done_cnt++;
    if (cmd_err) err_cnt++;
    if (vr_wr_en) begin
      if (exp_wr.size() == 0) chk("unexpected_wr", 1, 0);
      else begin
        w = exp_wr.pop_front();
        chk("wr_idx", vr_wr_idx, w.idx);
        chk("wr_data", vr_wr_data, w.data);
      end
    end
    mem_done = 0;
    if (pending) begin
      cnt--;
      if (cnt == 0) begin
        pending = 0;
        mem_done = !no_done;
        mem_dout = mem[pb][pa];
      end
    end
    if (mem_start && stall > 0) begin
      mem_ready = 0;
      stall--;
    end else mem_ready = 1;
    if (mem_start && !mem_ready && exp_acc.size() != 0) chk("stall_addr", mem_addr, exp_acc[0].addr);
    if (mem_start && mem_ready) begin
      acc_cnt++;
      if (exp_acc.size() == 0) chk("unexpected_acc", 1, 0);
      else begin
        a = exp_acc.pop_front();
        chk("acc_rw", mem_rw, a.rw);
        chk("acc_bank", mem_bank, a.bank);
        chk("acc_addr", mem_addr, a.addr);
        if (a.rw) chk("acc_din", mem_din, a.din);
      end
      if (mem_rw) mem[mem_bank][mem_addr] = mem_din;
      pending = 1;
      cnt = lat;
      pb = mem_bank;
      pa = mem_addr;
    end
  end

  task automatic push(input bit rw, input logic [5:0] addr, input logic [2:0] bank,
                      input logic [5:0] stride, input int na, input int nw);
    acc_t a;
    for (int i = 0; i < na; i++) begin
      a.rw = rw;
      a.bank = bank;
      a.addr = addr + 6'(i * stride);
      a.din = vr[i];
      exp_acc.push_back(a);
      if (!rw && i < nw) exp_wr.push_back({3'(i), mem[bank][a.addr]});
    end
  endtask

  task automatic send(input bit rw, input logic [5:0] addr, input logic [2:0] bank,
                      input logic [5:0] stride, input logic [3:0] len);
    cmd_rw = rw; cmd_addr = addr; cmd_bank = bank; cmd_stride = stride; cmd_len = len;
    cmd_valid = 1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_end(output int c);
    c = 0;
    while (!(cmd_done || cmd_err) && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("end_bound", c < 200, 1);
  endtask

  task automatic finish_cmd(input string tag, input int d0, input int e0, input int dd, input int de);
    @(negedge clk);
    #1;
    chk({tag, "_ready"}, cmd_ready, 1);
    chk({tag, "_done"}, done_cnt - d0, dd);
    chk({tag, "_err"}, err_cnt - e0, de);
    chk({tag, "_acc_left"}, exp_acc.size(), 0);
    chk({tag, "_wr_left"}, exp_wr.size(), 0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ctl"}, {cmd_ready, mem_start, mem_rw, mem_addr, mem_bank, vr_wr_en, vr_wr_idx,
                        cmd_done, cmd_err, vr_rd_idx}, 64'h100000);
    chk({tag, "_din"}, mem_din, 0);
    chk({tag, "_wrd"}, vr_wr_data, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int c, k, a0, d0, e0;
    for (int b = 0; b < 8; b++)
      for (int a = 0; a < 64; a++) mem[b][a] = 32'h5000 + 32'(b * 64 + a);
    for (int i = 0; i < 8; i++) vr[i] = 32'(100 + 3 * i);
    vr[0] = 45;
    vr[1] = 50;
    repeat (3) @(negedge clk);
    check_reset("reset");
    reset = 0;
    @(negedge clk);

    // store then load, stride 1
    d0 = done_cnt; e0 = err_cnt;
    push(1, 0, 0, 1, 2, 0);
    send(1, 0, 0, 1, 2);
    wait_end(c);
    finish_cmd("store", d0, e0, 1, 0);
    d0 = done_cnt;
    push(0, 0, 0, 1, 2, 2);
    chk("load_exp0", exp_wr[0].data, 45);
    chk("load_exp1", exp_wr[1].data, 50);
    send(0, 0, 0, 1, 2);
    wait_end(c);
    finish_cmd("load", d0, e0, 1, 0);

    // stride wrap 60,62,0,2 on bank 5
    d0 = done_cnt;
    push(0, 60, 5, 2, 4, 4);
    chk("wrap_addr2", exp_acc[2].addr, 0);
    send(0, 60, 5, 2, 4);
    wait_end(c);
    finish_cmd("wrap", d0, e0, 1, 0);

    // length clamped to VLEN
    d0 = done_cnt;
    push(1, 7, 1, 3, VLEN, 0);
    send(1, 7, 1, 3, 15);
    wait_end(c);
    finish_cmd("clamp", d0, e0, 1, 0);

    // zero length: done right after accept, no access
    d0 = done_cnt; a0 = acc_cnt;
    send(0, 5, 1, 1, 0);
    chk("len0_done_pulse", cmd_done, 1);
    chk("len0_start", mem_start, 0);
    finish_cmd("len0", d0, e0, 1, 0);
    chk("len0_pulse_width", cmd_done, 0);
    chk("len0_acc", acc_cnt - a0, 0);

    // mem_ready stall for 5 cycles
    d0 = done_cnt; a0 = acc_cnt;
    stall = 5;
    push(0, 20, 2, 1, 1, 1);
    send(0, 20, 2, 1, 1);
    wait_end(c);
    finish_cmd("stall", d0, e0, 1, 0);
    chk("stall_acc", acc_cnt - a0, 1);
    chk("stall_used", stall, 0);

    // watchdog: no done ever
    d0 = done_cnt;
    no_done = 1;
    push(0, 10, 3, 1, 1, 0);
    send(0, 10, 3, 1, 2);
    wait_end(c);
    chk("wd_cycles", c, TIMEOUT + 1);
    chk("wd_err_pulse", cmd_err, 1);
    finish_cmd("wd", d0, e0, 0, 1);
    no_done = 0;
    repeat (3) @(negedge clk);
    d0 = done_cnt; e0 = err_cnt;
    push(0, 11, 3, 1, 1, 1);
    send(0, 11, 3, 1, 1);
    wait_end(c);
    finish_cmd("after_wd", d0, e0, 1, 0);

    // done arriving on the last watchdog cycle wins
    d0 = done_cnt;
    lat = TIMEOUT;
    push(0, 30, 4, 5, 2, 2);
    send(0, 30, 4, 5, 2);
    wait_end(c);
    finish_cmd("done_vs_wd", d0, e0, 1, 0);
    lat = 1;

    // reset during WAIT of element 2 of 4
    d0 = done_cnt; a0 = acc_cnt;
    lat = 3;
    push(0, 40, 6, 1, 3, 2);
    send(0, 40, 6, 1, 4);
    k = 0;
    while (acc_cnt < a0 + 3 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("rst_reach_elem2", k < 100, 1);
    @(negedge clk);
    reset = 1;
    #1;
    check_reset("midreset");
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    repeat (5) @(negedge clk);
    #1;
    chk("midreset_done", done_cnt - d0, 0);
    chk("midreset_err", err_cnt - e0, 0);
    chk("midreset_acc_left", exp_acc.size(), 0);
    chk("midreset_wr_left", exp_wr.size(), 0);
    lat = 1;
    d0 = done_cnt;
    push(0, 40, 6, 1, 2, 2);
    send(0, 40, 6, 1, 2);
    wait_end(c);
    finish_cmd("post_reset", d0, e0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
